// File: rtl/program_memory_arbiter_if.sv
// program_memory_arbiter_if: fetch/data request ports plus the program memory bus
interface program_memory_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic                  f_req_i;
  logic [DATA_WIDTH-1:0] f_addr_i;
  logic                  f_gnt_o;
  logic                  f_rvalid_o;
  logic                  d_req_i;
  logic [DATA_WIDTH-1:0] d_addr_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  modport slave (
    input  f_req_i, f_addr_i, d_req_i, d_addr_i, mem_rdata_i,
    output f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o, rdata_o, err_o, mem_addr_o
  );
  modport master (
    output f_req_i, f_addr_i, d_req_i, d_addr_i, mem_rdata_i,
    input  f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o, rdata_o, err_o, mem_addr_o
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares the program memory between fetch and data ports with wait states
module program_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 32,
  parameter int WAIT_CYCLES  = 0,
  parameter int ROUND_ROBIN  = 1
) (
  input logic                   clk,
  input logic                   reset,
  program_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  prio_q, sel_q, ce_q, f_rvalid_q, d_rvalid_q, err_q;
  logic [DATA_WIDTH-1:0] addr_q, rdata_q;
  logic                  both, pick_d, gnt, gerr, nsel, nerr, enter_resp;
  logic [DATA_WIDTH-1:0] gaddr;
  // Pick the winner, flag bad addresses and work out whether this edge enters RESP
  always_comb begin
    both       = bus.f_req_i & bus.d_req_i;
    pick_d     = both ? (ROUND_ROBIN != 0 && prio_q) : bus.d_req_i;
    gnt        = !reset && state_q != WAIT && (bus.f_req_i | bus.d_req_i);
    gaddr      = pick_d ? bus.d_addr_i : bus.f_addr_i;
    gerr       = gaddr[1:0] != 2'b00 || {2'b00, gaddr[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEMORY_DEPTH);
    enter_resp = gnt ? WAIT_CYCLES == 0 : state_q == WAIT && cnt_q == 4'd0;
    nsel       = gnt ? pick_d : sel_q;
    nerr       = gnt ? gerr : ce_q;
  end
  // Access sequencing: capture on grant, count wait states, register the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      prio_q     <= 1'b0;
      sel_q      <= 1'b0;
      ce_q       <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      rdata_q    <= '0;
    end else begin
      f_rvalid_q <= enter_resp & ~nsel;
      d_rvalid_q <= enter_resp & nsel;
      err_q      <= enter_resp & nerr;
      if (enter_resp) rdata_q <= nerr ? '0 : bus.mem_rdata_i;
      if (gnt) begin
        addr_q  <= gaddr;
        sel_q   <= pick_d;
        ce_q    <= gerr;
        cnt_q   <= 4'(WAIT_CYCLES - 1);
        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        if (both) prio_q <= ~pick_d;
      end else if (state_q == WAIT) begin
        cnt_q   <= cnt_q - 4'd1;
        state_q <= (cnt_q == 4'd0) ? RESP : WAIT;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign bus.f_gnt_o    = gnt & ~pick_d;
  assign bus.d_gnt_o    = gnt & pick_d;
  assign bus.f_rvalid_o = f_rvalid_q;
  assign bus.d_rvalid_o = d_rvalid_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.mem_addr_o = gnt ? gaddr : addr_q;
endmodule
